// File: rtl/qpu_exu_cwbck_arbiter.sv
// qpu_exu_cwbck_arbiter: shares the regfile writeback port between the ALU and a FIFO of long-pipe results; QPU_CWBCK_STARVE_GUARD_EN enables the starvation guard
module qpu_exu_cwbck_arbiter #(
  parameter int XLEN = 32,
  parameter int RFIDX_W = 6,
  parameter int LP_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_valid,
  output logic               alu_wbck_ready,
  input  logic [RFIDX_W-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]    alu_wbck_data,
  input  logic               lp_wbck_valid,
  output logic               lp_wbck_ready,
  input  logic [RFIDX_W-1:0] lp_wbck_idx,
  input  logic [XLEN-1:0]    lp_wbck_data,
  output logic               cwbck_dest_wen,
  output logic [RFIDX_W-1:0] cwbck_dest_idx,
  output logic [XLEN-1:0]    cwbck_dest_data,
  output logic               lp_fifo_empty,
  output logic               wbck_idx_err
);
  localparam int PW = LP_DEPTH > 1 ? $clog2(LP_DEPTH) : 1;
  localparam int CW = $clog2(LP_DEPTH + 1);
  if (LP_DEPTH < 1 || STARVE_MAX < 1) begin : g_bad_cfg
    $error("LP_DEPTH and STARVE_MAX must be at least 1");
  end
  logic [RFIDX_W-1:0] fifo_idx [LP_DEPTH];
  logic [XLEN-1:0]    fifo_data [LP_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic               fifo_empty, force_lp, grant_alu, grant_lp, grant, push;
  logic [RFIDX_W-1:0] win_idx;
  logic [XLEN-1:0]    win_data;
  assign fifo_empty    = count == '0;
  assign lp_fifo_empty = fifo_empty;
  assign lp_wbck_ready = count < CW'(LP_DEPTH);
  assign push          = lp_wbck_valid & lp_wbck_ready;
  // ALU wins unless the guard forces the FIFO head through; a fresh push is never poppable in its own cycle
  always_comb begin
    grant_alu      = alu_wbck_valid & ~force_lp;
    grant_lp       = ~fifo_empty & ~grant_alu;
    grant          = grant_alu | grant_lp;
    alu_wbck_ready = grant_alu;
    win_idx        = grant_alu ? alu_wbck_idx : fifo_idx[rd_ptr];
    win_data       = grant_alu ? alu_wbck_data : fifo_data[rd_ptr];
  end
`ifdef QPU_CWBCK_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  // count consecutive ALU wins while the FIFO waits, saturating at the force threshold
  always_ff @(posedge clk) begin
    if (!rst_n || fifo_empty || grant_lp) starve_cnt <= '0;
    else if (grant_alu && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end
  assign force_lp = (starve_cnt == SW'(STARVE_MAX)) & ~fifo_empty;
`else
  assign force_lp = 1'b0;
`endif
  // circular long-pipe FIFO; reset discards all pending entries
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_idx[wr_ptr]  <= lp_wbck_idx;
        fifo_data[wr_ptr] <= lp_wbck_data;
        wr_ptr            <= wr_ptr == PW'(LP_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (grant_lp) rd_ptr <= rd_ptr == PW'(LP_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(grant_lp);
    end
  end
  // registered writeback port; x0 and quantum-index writes are consumed without a write enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cwbck_dest_wen  <= 1'b0;
      cwbck_dest_idx  <= '0;
      cwbck_dest_data <= '0;
      wbck_idx_err    <= 1'b0;
    end else begin
      cwbck_dest_wen <= grant & ~win_idx[RFIDX_W-1] & (win_idx[RFIDX_W-2:0] != '0);
      if (grant) begin
        cwbck_dest_idx  <= win_idx;
        cwbck_dest_data <= win_data;
      end
      if (grant & win_idx[RFIDX_W-1]) wbck_idx_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_qpu_exu_cwbck_arbiter.sv
// tb_qpu_exu_cwbck_arbiter: directed and random checks of the writeback arbiter against a queue-based model
module tb_qpu_exu_cwbck_arbiter;
  localparam int XLEN = 32;
  localparam int RFIDX_W = 6;
  localparam int LP_DEPTH = 2;
  localparam int STARVE_MAX = 4;
`ifdef QPU_CWBCK_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic alu_wbck_valid, alu_wbck_ready, lp_wbck_valid, lp_wbck_ready;
  logic [RFIDX_W-1:0] alu_wbck_idx, lp_wbck_idx, cwbck_dest_idx;
  logic [XLEN-1:0] alu_wbck_data, lp_wbck_data, cwbck_dest_data;
  logic cwbck_dest_wen, lp_fifo_empty, wbck_idx_err;
  qpu_exu_cwbck_arbiter #(
    .XLEN(XLEN), .RFIDX_W(RFIDX_W), .LP_DEPTH(LP_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_idx(alu_wbck_idx), .alu_wbck_data(alu_wbck_data),
    .lp_wbck_valid(lp_wbck_valid), .lp_wbck_ready(lp_wbck_ready),
    .lp_wbck_idx(lp_wbck_idx), .lp_wbck_data(lp_wbck_data),
    .cwbck_dest_wen(cwbck_dest_wen), .cwbck_dest_idx(cwbck_dest_idx),
    .cwbck_dest_data(cwbck_dest_data), .lp_fifo_empty(lp_fifo_empty),
    .wbck_idx_err(wbck_idx_err)
  );
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  logic [RFIDX_W+XLEN-1:0] q[$];
  int m_starve = 0;
  logic m_wen, m_err;
  logic [RFIDX_W-1:0] m_idx;
  logic [XLEN-1:0] m_data;
  bit known = 1'b0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic [RFIDX_W+XLEN-1:0] w;
    bit fl, ga, gl, pr;
    fl = GUARD && m_starve == STARVE_MAX && q.size() > 0;
    ga = alu_wbck_valid && !fl;
    gl = q.size() > 0 && !ga;
    pr = q.size() < LP_DEPTH;
    if (known) begin
      check("alu_ready", alu_wbck_ready, ga);
      check("lp_ready", lp_wbck_ready, pr);
      check("empty_pre", lp_fifo_empty, q.size() == 0);
    end
    w = ga ? {alu_wbck_idx, alu_wbck_data} : (gl ? q[0] : '0);
    if (!rst_n) begin
      q.delete();
      m_starve = 0;
      m_wen = 0; m_idx = 0; m_data = 0; m_err = 0;
      known = 1'b1;
    end else begin
      if (GUARD) m_starve = (q.size() == 0 || gl) ? 0 : ((ga && m_starve < STARVE_MAX) ? m_starve + 1 : m_starve);
      if (gl) void'(q.pop_front());
      if (lp_wbck_valid && pr) q.push_back({lp_wbck_idx, lp_wbck_data});
      m_wen = 0;
      if (ga || gl) begin
        m_idx = w[RFIDX_W+XLEN-1:XLEN];
        m_data = w[XLEN-1:0];
        m_wen = !m_idx[RFIDX_W-1] && m_idx != 0;
        if (m_idx[RFIDX_W-1]) m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    if (known) begin
      check("wen", cwbck_dest_wen, m_wen);
      check("idx", cwbck_dest_idx, m_idx);
      check("data", cwbck_dest_data, m_data);
      check("err", wbck_idx_err, m_err);
      check("empty", lp_fifo_empty, q.size() == 0);
    end
  endtask
  task automatic idle();
    alu_wbck_valid = 0; lp_wbck_valid = 0;
  endtask
  initial begin
    rst_n = 0; idle();
    alu_wbck_idx = 0; alu_wbck_data = 0; lp_wbck_idx = 0; lp_wbck_data = 0;
    cycle(); cycle();
    check("rst_wen", cwbck_dest_wen, 0);
    check("rst_empty", lp_fifo_empty, 1);
    rst_n = 1;
    // ALU single write, 1-cycle latency
    alu_wbck_valid = 1; alu_wbck_idx = 5; alu_wbck_data = 32'hDEADBEEF;
    check("t1_ready", alu_wbck_ready, 1);
    cycle();
    check("t1_wen", cwbck_dest_wen, 1);
    check("t1_data", cwbck_dest_data, 32'hDEADBEEF);
    // long-pipe write, 2-cycle latency
    idle(); lp_wbck_valid = 1; lp_wbck_idx = 3; lp_wbck_data = 1;
    cycle();
    idle();
    check("t2_wait_wen", cwbck_dest_wen, 0);
    cycle();
    check("t2_wen", cwbck_dest_wen, 1);
    check("t2_idx", cwbck_dest_idx, 3);
    check("t2_empty", lp_fifo_empty, 1);
    // fill FIFO while ALU busy, then drain in order
    alu_wbck_valid = 1; alu_wbck_idx = 9; lp_wbck_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_wbck_data = 32'h100 + i; lp_wbck_idx = RFIDX_W'(10 + i); lp_wbck_data = 32'hA0 + i;
      if (i == 2) check("t3_full", lp_wbck_ready, 0);
      cycle();
    end
    idle();
    cycle();
    check("t3_first", cwbck_dest_data, 32'hA0);
    cycle();
    check("t3_second", cwbck_dest_data, 32'hA1);
    // one FIFO entry against a continuously busy ALU
    alu_wbck_valid = 1; alu_wbck_idx = 4; lp_wbck_valid = 1; lp_wbck_idx = 7; lp_wbck_data = 32'h1234;
    cycle();
    lp_wbck_valid = 0;
    for (int i = 0; i < 6; i++) begin
      alu_wbck_data = 32'h200 + i;
      check("t4_ready", alu_wbck_ready, !(GUARD && i == 4));
      cycle();
      if (GUARD && i == 4) check("t4_lp_data", cwbck_dest_data, 32'h1234);
    end
    check("t4_empty", lp_fifo_empty, GUARD);
    idle();
    cycle();
    // x0 and quantum-index writes are consumed silently, the quantum one flags an error
    alu_wbck_valid = 1; alu_wbck_idx = 0; alu_wbck_data = 32'h55;
    lp_wbck_valid = 1; lp_wbck_idx = 6'b100010; lp_wbck_data = 1;
    check("t5_lp_ready", lp_wbck_ready, 1);
    cycle();
    check("t5_alu_wen", cwbck_dest_wen, 0);
    idle();
    cycle();
    check("t5_err", wbck_idx_err, 1);
    check("t5_lp_wen", cwbck_dest_wen, 0);
    // reset with two entries pending
    alu_wbck_valid = 1; alu_wbck_idx = 2; lp_wbck_valid = 1; lp_wbck_idx = 12;
    cycle(); cycle();
    rst_n = 0;
    cycle();
    check("t6_empty", lp_fifo_empty, 1);
    check("t6_err", wbck_idx_err, 0);
    rst_n = 1; idle();
    cycle();
    cycle();
    check("t6_no_stale", cwbck_dest_wen, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      alu_wbck_valid = $urandom_range(0, 3) != 0;
      lp_wbck_valid = $urandom_range(0, 1) != 0;
      alu_wbck_idx = RFIDX_W'($urandom_range(0, 40));
      lp_wbck_idx = RFIDX_W'($urandom_range(0, 40));
      alu_wbck_data = $urandom;
      lp_wbck_data = $urandom;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
